hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and mul/div EX occupancy control.
// Optional performance counters (stall_cnt, flush_cnt) exist only with HAZ_PERF_EN.
module hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_muldiv,
    input  logic        ex_redirect,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic        md_done
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 2);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   md_cnt_q, md_cnt_d;
    logic            rs1_hit, rs2_hit, load_use;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_memread && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        md_done     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (ex_muldiv) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    ex_hold   = 1'b1;
                    state_d   = MD_BUSY;
                    md_cnt_d  = MD_INIT;
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q != '0) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    ex_hold   = 1'b1;
                    md_cnt_d  = md_cnt_q - 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
        endcase

        // Outputs must drop the moment reset asserts, not at the next edge.
        if (!rst_n) begin
            pc_hold     = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            ex_hold     = 1'b0;
            md_done     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, pc_hold};
        flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
